// File: rtl/count_sequencer_pkg.sv
// Shared state encoding for the count sequencer FSM.
package count_sequencer_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } seq_state_e;

endpackage

// File: rtl/count_sequencer_rate_prescaler.sv
// Rate prescaler: free-running 0..PRESCALE-1 counter gated by run, tick on the last phase.
module rate_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;

    always_comb begin
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (run) begin
            pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    assign tick = (pre_q == PRE_MAX);

endmodule

// File: rtl/count_sequencer.sv
// Run/pause/terminal-count sequencer for the enable-driven up counter datapath.
// Optional feature: COUNT_SEQUENCER_AUTORELOAD_EN (DONE becomes a 1-cycle pulse, then auto re-run).
module count_sequencer
    import count_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Clear,
    input  logic [WIDTH-1:0] Limit,
    input  logic [WIDTH-1:0] Count,
    input  logic             Carry,
    output logic             CntEn,
    output logic             CntRst,
    output logic             Busy,
    output logic             Done,
    output logic             Err,
    output logic [1:0]       State
);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             cnt_rst_q, cnt_rst_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick;
    logic             at_limit;

    // Pre is held at zero outside RUN/PAUSE so every entry into RUN from IDLE or DONE starts a fresh period.
    rate_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (Clk),
        .rst (Rst),
        .run ((state_q == S_RUN) && !Stop && !Clear),
        .clr ((state_q == S_IDLE) || (state_q == S_DONE)),
        .tick(tick)
    );

    assign at_limit = (Count == limit_q);
    assign CntEn    = (state_q == S_RUN) && tick && !at_limit && !Stop && !Clear;

    always_comb begin
        state_d = state_q;
        limit_d = limit_q;
        err_d   = Clear ? 1'b0 : (err_q | (Carry & CntEn));
        unique case (state_q)
            S_IDLE: begin
                if (Start && !Stop && !Clear) begin
                    state_d = S_RUN;
                    limit_d = Limit;
                end
            end
            S_RUN: begin
                if (Clear) begin
                    state_d = S_IDLE;
                end else if (Stop) begin
                    state_d = S_PAUSE;
                end else if (at_limit) begin
                    state_d = S_DONE;
                end
            end
            S_PAUSE: begin
                if (Clear) begin
                    state_d = S_IDLE;
                end else if (Start && !Stop) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
`ifdef COUNT_SEQUENCER_AUTORELOAD_EN
                state_d = Clear ? S_IDLE : S_RUN;
`else
                if (Clear || Start) begin
                    state_d = S_IDLE;
                end
`endif
            end
        endcase

        // In autoreload the counter is cleared during the single DONE cycle so RUN resumes from zero.
`ifdef COUNT_SEQUENCER_AUTORELOAD_EN
        cnt_rst_d = (state_d == S_IDLE) || (state_d == S_DONE);
`else
        cnt_rst_d = (state_d == S_IDLE);
`endif
        busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            limit_q   <= '0;
            cnt_rst_q <= 1'b1;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            limit_q   <= limit_d;
            cnt_rst_q <= cnt_rst_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign CntRst = cnt_rst_q;
    assign Err    = err_q;
    assign Busy   = busy_q;
    assign Done   = done_q;
    assign State  = state_q;

endmodule
